// File: rtl/pipe_trace_buffer_pkg.sv
// rtl/pipe_trace_buffer_pkg.sv - shared states, opcodes and control-vector layout for the pipeline trace buffer
package pipe_trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_POST  = 3'd2,
    ST_DONE  = 3'd3,
    ST_READ  = 3'd4
  } trace_state_e;

  // Opcodes commonly used as trigger targets
  localparam logic [5:0] OP_LDW   = 6'b010010;
  localparam logic [5:0] OP_STW   = 6'b011010;
  localparam logic [5:0] OP_BL    = 6'b111010;
  localparam logic [5:0] OP_COMBT = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b101101;

  // LSB offsets of the fields inside the 24-bit packed EX control vector
  localparam int CTRL_COMB_LSB     = 0;   // 5 bits
  localparam int CTRL_CO_EN_LSB    = 5;
  localparam int CTRL_PSW_EN_LSB   = 6;
  localparam int CTRL_RF_LE_LSB    = 7;
  localparam int CTRL_SR_LSB       = 8;   // 3 bits
  localparam int CTRL_L_LSB        = 11;
  localparam int CTRL_RAM_CTRL_LSB = 12;  // 4 bits
  localparam int CTRL_ALU_OP_LSB   = 16;  // 4 bits
  localparam int CTRL_SOH_OP_LSB   = 20;  // 3 bits
  localparam int CTRL_BL_LSB       = 23;

  localparam int TS_W = 16;

  // A trigger mask bit of 1 means that opcode bit must equal trig_op
  function automatic logic op_match(input logic [5:0] op, input logic [5:0] trig,
                                    input logic [5:0] mask);
    return ((op ^ trig) & mask) == 6'b0;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// rtl/pipe_trace_buffer_if.sv - capture, control and readout bus of the trace buffer (honours TRACE_TIMESTAMP_EN)
interface pipe_trace_buffer_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int CTRL_W = 24,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int TW = PC_W + INST_W + CTRL_W + 16;
`else
  localparam int TW = PC_W + INST_W + CTRL_W;
`endif

  logic              arm;
  logic [5:0]        trig_op;
  logic [5:0]        trig_mask;
  logic [AW-1:0]     post_cnt;
  logic              cap_valid;
  logic [PC_W-1:0]   cap_pc;
  logic [INST_W-1:0] cap_inst;
  logic [CTRL_W-1:0] cap_ctrl;
  logic              rd_req;
  logic              rd_valid;
  logic              rd_last;
  logic [TW-1:0]     rd_data;
  logic [2:0]        state;
  logic              wrapped;
  logic [AW:0]       count;

  modport master (
    output arm, trig_op, trig_mask, post_cnt, cap_valid, cap_pc, cap_inst, cap_ctrl, rd_req,
    input  rd_valid, rd_last, rd_data, state, wrapped, count
  );

  modport slave (
    input  arm, trig_op, trig_mask, post_cnt, cap_valid, cap_pc, cap_inst, cap_ctrl, rd_req,
    output rd_valid, rd_last, rd_data, state, wrapped, count
  );

endinterface

// File: rtl/pipe_trace_buffer_trace_ram.sv
// rtl/pipe_trace_buffer_trace_ram.sv - simple dual-port trace storage, sync write, registered read
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 88
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage array is left unreset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register clears on reset so the readout bus idles at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - ID/EX trace capture with masked-opcode trigger and oldest-first dump (optional TRACE_TIMESTAMP_EN)
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int CTRL_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  pipe_trace_buffer_if.slave  trc
);

  localparam int AW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int TW = PC_W + INST_W + CTRL_W + TS_W;
`else
  localparam int TW = PC_W + INST_W + CTRL_W;
`endif
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  trace_state_e  st;
  logic [AW-1:0] wr_ptr, rd_ptr, post_ctr, rd_addr;
  logic [AW:0]   cnt, beats_left;
  logic          wrap_q, rd_valid_q, rd_last_q;
  logic          hit, wr_en, rd_en, last_issue;
  logic [TW-1:0] wr_entry, ram_q;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  // Free-running cycle stamp, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts <= '0;
    else        ts <= ts + 1'b1;
  end

  assign wr_entry = {trc.cap_pc, trc.cap_inst, trc.cap_ctrl, ts};
`else
  assign wr_entry = {trc.cap_pc, trc.cap_inst, trc.cap_ctrl};
`endif

  assign hit   = op_match(trc.cap_inst[INST_W-1 -: 6], trc.trig_op, trc.trig_mask);
  // arm takes priority over capture, so the arming cycle is never recorded
  assign wr_en = (st == ST_ARMED || st == ST_POST) && trc.cap_valid && !trc.arm;

  // Read address issue: the rd_req cycle issues the oldest entry, READ issues the rest
  always_comb begin
    rd_en      = 1'b0;
    rd_addr    = rd_ptr;
    last_issue = 1'b0;
    if (!trc.arm) begin
      if (st == ST_DONE && trc.rd_req) begin
        rd_en      = 1'b1;
        rd_addr    = wrap_q ? wr_ptr : '0;
        last_issue = (cnt == ONE);
      end else if (st == ST_READ && beats_left != '0) begin
        rd_en      = 1'b1;
        last_issue = (beats_left == ONE);
      end
    end
  end

  // Control FSM with write pointer, occupancy, post-trigger window and dump sequencing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      wrap_q     <= 1'b0;
      post_ctr   <= '0;
      beats_left <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_last_q  <= rd_en && last_issue;
      if (trc.arm) begin
        st     <= ST_ARMED;
        wr_ptr <= '0;
        cnt    <= '0;
        wrap_q <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (cnt == FULL) wrap_q <= 1'b1;
          else             cnt    <= cnt + 1'b1;
        end
        if (rd_en) rd_ptr <= rd_addr + 1'b1;
        case (st)
          ST_ARMED: begin
            // post_cnt is only AW bits wide, so it can never exceed DEPTH-1
            if (trc.cap_valid && hit) begin
              post_ctr <= trc.post_cnt;
              st       <= (trc.post_cnt == '0) ? ST_DONE : ST_POST;
            end
          end
          ST_POST: begin
            if (trc.cap_valid) begin
              post_ctr <= post_ctr - 1'b1;
              if (post_ctr == AW'(1)) st <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (trc.rd_req) begin
              beats_left <= cnt - ONE;
              st         <= ST_READ;
            end
          end
          ST_READ: begin
            if (beats_left != '0) beats_left <= beats_left - ONE;
            if (rd_last_q)        st         <= ST_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  trace_ram #(.DEPTH(DEPTH), .W(TW)) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  assign trc.rd_valid = rd_valid_q;
  assign trc.rd_last  = rd_last_q;
  assign trc.rd_data  = ram_q;
  assign trc.state    = st;
  assign trc.wrapped  = wrap_q;
  assign trc.count    = cnt;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - scoreboard bench for pipe_trace_buffer (timestamp checks under TRACE_TIMESTAMP_EN)
`timescale 1ns/1ps
module tb_pipe_trace_buffer;
  import pipe_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int EW    = 88;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TW = EW + 16;
`else
  localparam int TW = EW;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_trace_buffer_if #(.PC_W(32), .INST_W(32), .CTRL_W(24), .DEPTH(DEPTH)) trc();

  pipe_trace_buffer #(.PC_W(32), .INST_W(32), .CTRL_W(24), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .trc   (trc)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [EW-1:0] buf_q[$];
  logic [EW-1:0] exp_q[$];
  int            m_state;
  int            m_post;
  int            m_postcfg;
  bit            m_wrapped;
  logic [5:0]    m_op, m_mask;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [31:0] pc, input logic [5:0] op);
    return {pc, op, pc[25:0], pc[23:0] ^ 24'h5A5A5A};
  endfunction

  // Reference behaviour of one valid capture reaching the buffer
  function automatic void model_cap(input logic [EW-1:0] e, input logic [5:0] op);
    if (m_state == 1 || m_state == 2) begin
      if (buf_q.size() == DEPTH) begin
        void'(buf_q.pop_front());
        m_wrapped = 1'b1;
      end
      buf_q.push_back(e);
      if (m_state == 1) begin
        if (((op ^ m_op) & m_mask) == 6'b0) begin
          m_post  = m_postcfg;
          m_state = (m_post == 0) ? 3 : 2;
        end
      end else begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
    end
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [5:0] op, input bit v);
    logic [EW-1:0] e;
    e = mk(pc, op);
    trc.cap_valid = v;
    trc.cap_pc    = e[87:56];
    trc.cap_inst  = e[55:24];
    trc.cap_ctrl  = e[23:0];
  endtask

  task automatic cap(input logic [31:0] pc, input logic [5:0] op, input bit v);
    @(negedge clk);
    drive(pc, op, v);
    if (v) model_cap(mk(pc, op), op);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      trc.cap_valid = 1'b0;
    end
  endtask

  task automatic do_arm(input logic [5:0] op, input logic [5:0] mask, input int post,
                        input bit with_cap, input logic [5:0] cap_op);
    @(negedge clk);
    trc.arm       = 1'b1;
    trc.trig_op   = op;
    trc.trig_mask = mask;
    trc.post_cnt  = AW'(post);
    drive(32'd999, cap_op, with_cap);
    m_op = op; m_mask = mask; m_postcfg = post;
    buf_q.delete();
    m_wrapped = 1'b0;
    m_state   = 1;
    @(negedge clk);
    trc.arm       = 1'b0;
    trc.cap_valid = 1'b0;
    chk("arm_state", 128'(trc.state), 128'(ST_ARMED));
    chk("arm_count", 128'(trc.count), 128'(0));
    chk("arm_rd_valid", 128'(trc.rd_valid), 128'(0));
  endtask

  task automatic dump(input string tag, input bit ts_consec);
    int            beats;
    int            guard;
    bit            seen_last;
    bit            have_prev;
    logic [15:0]   prev_ts;
    logic [EW-1:0] e;
    exp_q = buf_q;
    have_prev = 1'b0;
    prev_ts   = '0;
    chk({tag, "_state"}, 128'(trc.state), 128'(ST_DONE));
    chk({tag, "_count"}, 128'(trc.count), 128'(buf_q.size()));
    chk({tag, "_wrapped"}, 128'(trc.wrapped), 128'(m_wrapped));
    @(negedge clk);
    trc.rd_req = 1'b1;
    @(negedge clk);
    trc.rd_req = 1'b0;
    beats = 0; guard = 0; seen_last = 1'b0;
    while (!seen_last && guard < DEPTH + 4) begin
      if (trc.rd_valid) begin
        beats++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk({tag, "_data"}, 128'(trc.rd_data[TW-1 -: EW]), 128'(e));
          chk({tag, "_last"}, 128'(trc.rd_last), 128'(exp_q.size() == 0));
        end
`ifdef TRACE_TIMESTAMP_EN
        if (ts_consec && have_prev)
          chk({tag, "_stamp"}, 128'(trc.rd_data[15:0]), 128'(prev_ts + 16'd1));
        prev_ts   = trc.rd_data[15:0];
        have_prev = 1'b1;
`endif
        seen_last = trc.rd_last;
      end
      @(negedge clk);
      guard++;
    end
    chk({tag, "_finished"}, 128'(seen_last), 128'(1));
    chk({tag, "_beats"}, 128'(beats), 128'(buf_q.size()));
    chk({tag, "_back_done"}, 128'(trc.state), 128'(ST_DONE));
    chk({tag, "_idle_valid"}, 128'(trc.rd_valid), 128'(0));
  endtask

  initial begin
    trc.arm = 1'b0; trc.trig_op = '0; trc.trig_mask = '0; trc.post_cnt = '0;
    trc.cap_valid = 1'b0; trc.cap_pc = '0; trc.cap_inst = '0; trc.cap_ctrl = '0;
    trc.rd_req = 1'b0;
    m_state = 0; m_post = 0; m_postcfg = 0; m_wrapped = 1'b0; m_op = '0; m_mask = '0;

    #1;
    chk("rst_state", 128'(trc.state), 128'(ST_IDLE));
    chk("rst_count", 128'(trc.count), 128'(0));
    chk("rst_wrapped", 128'(trc.wrapped), 128'(0));
    chk("rst_rd_valid", 128'(trc.rd_valid), 128'(0));
    chk("rst_rd_data", 128'(trc.rd_data), 128'(0));
    @(negedge clk);
    reset = 1'b1;

    // 1: immediate trigger, 3-entry post window, repeatable dump
    do_arm(OP_ADDI, 6'h00, 3, 1'b0, OP_ADDI);
    for (int i = 0; i < 10; i++) cap(32'(i), OP_ADDI, 1'b1);
    idle(2);
    dump("t1", 1'b1);
    dump("t1_again", 1'b1);

    // 2: BL trigger after 20 other instructions, full window wraps
    do_arm(OP_BL, 6'h3F, 15, 1'b0, OP_ADDI);
    for (int i = 0; i < 20; i++) cap(32'(i), (i % 2) ? OP_STW : OP_ADDI, 1'b1);
    cap(32'd20, OP_BL, 1'b1);
    for (int i = 21; i < 38; i++) cap(32'(i), OP_ADDI, 1'b1);
    idle(2);
    dump("t2", 1'b1);

    // 3: bubbles inside the post window are neither stored nor counted
    do_arm(OP_ADDI, 6'h00, 5, 1'b0, OP_ADDI);
    cap(32'd100, OP_ADDI, 1'b1);
    cap(32'd101, OP_COMBT, 1'b1);
    for (int i = 0; i < 5; i++) cap(32'(200 + i), OP_LDW, 1'b0);
    @(negedge clk);
    chk("t3_hold_state", 128'(trc.state), 128'(ST_POST));
    chk("t3_hold_count", 128'(trc.count), 128'(2));
    for (int i = 102; i < 106; i++) cap(32'(i), OP_ADDI, 1'b1);
    idle(2);
    dump("t3", 1'b0);

    // 4: zero post window, trigger entry is the last beat
    do_arm(OP_LDW, 6'h3F, 0, 1'b0, OP_ADDI);
    for (int i = 0; i < 7; i++) cap(32'(i), OP_ADDI, 1'b1);
    cap(32'd7, OP_LDW, 1'b1);
    cap(32'd8, OP_ADDI, 1'b1);
    idle(2);
    dump("t4", 1'b1);

    // 5: arming cycle carries a matching opcode; rd_req while ARMED is ignored
    do_arm(OP_LDW, 6'h3F, 1, 1'b1, OP_LDW);
    @(negedge clk);
    trc.rd_req = 1'b1;
    @(negedge clk);
    trc.rd_req = 1'b0;
    chk("t5_no_rd_valid", 128'(trc.rd_valid), 128'(0));
    @(negedge clk);
    chk("t5_no_rd_valid2", 128'(trc.rd_valid), 128'(0));
    chk("t5_still_armed", 128'(trc.state), 128'(ST_ARMED));
    cap(32'd50, OP_ADDI, 1'b1);
    cap(32'd51, OP_LDW, 1'b1);
    cap(32'd52, OP_STW, 1'b1);
    idle(2);
    dump("t5", 1'b1);

    // 6: reset asserted in the middle of a dump
    do_arm(OP_ADDI, 6'h00, 5, 1'b0, OP_ADDI);
    for (int i = 0; i < 6; i++) cap(32'(300 + i), OP_ADDI, 1'b1);
    idle(2);
    chk("t6_done", 128'(trc.state), 128'(ST_DONE));
    @(negedge clk);
    trc.rd_req = 1'b1;
    @(negedge clk);
    trc.rd_req = 1'b0;
    @(negedge clk);
    chk("t6_reading", 128'(trc.rd_valid), 128'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 128'(trc.rd_valid), 128'(0));
    chk("t6_rst_state", 128'(trc.state), 128'(ST_IDLE));
    chk("t6_rst_count", 128'(trc.count), 128'(0));
    chk("t6_rst_data", 128'(trc.rd_data), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    m_state = 0;
    buf_q.delete();
    @(negedge clk);
    chk("t6_after_state", 128'(trc.state), 128'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
